// File: rtl/typing_trainer_fsm_if.sv
// Bundle between the PS/2 decode stage, the typing trainer and the display/LED stage.
// The master side drives keys and commands; the slave side (the trainer) drives status.
interface typing_trainer_fsm_if #(
  parameter int ERR_W = 8
);
  logic [7:0]       fsm_data;
  logic             code_valid;
  logic             set_signal;
  logic             reset_signal;
  logic [7:0]       pos;
  logic [7:0]       expected_code;
  logic [ERR_W-1:0] err_cnt;
  logic             key_ok;
  logic             key_err;
  logic             busy;
  logic             done;
  logic             fail;

  modport master (
    output fsm_data, code_valid, set_signal, reset_signal,
    input  pos, expected_code, err_cnt, key_ok, key_err, busy, done, fail
  );

  modport slave (
    input  fsm_data, code_valid, set_signal, reset_signal,
    output pos, expected_code, err_cnt, key_ok, key_err, busy, done, fail
  );
endinterface

// File: rtl/typing_trainer_fsm.sv
// Typing-trainer session FSM: checks decoded keys against SEQ, tracks errors and timeout.
// Optional macro RETRY_ON_ERROR_EN: a mismatched key must be retyped instead of skipped.
module typing_trainer_fsm #(
  parameter int                   SEQ_LEN     = 4,
  parameter logic [SEQ_LEN*8-1:0] SEQ         = 32'h44332211,
  parameter int                   MAX_ERR     = 3,
  parameter int                   ERR_W       = 8,
  parameter int                   TIMEOUT_CYC = 50_000_000
) (
  input logic                 clk,
  input logic                 rst_n,
  typing_trainer_fsm_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

  localparam logic [7:0]       LEN8         = 8'(SEQ_LEN);
  localparam logic [31:0]      TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [ERR_W-1:0] ERR_SAT      = '1;

  state_t      state_reg;
  logic [31:0] timer_reg;

  // Full 256-entry table so pos==SEQ_LEN (and beyond) reads back as 8'h00.
  logic [7:0] seq_bytes [256];
  genvar gi;
  generate
    for (gi = 0; gi < 256; gi++) begin : g_seq
      if (gi < SEQ_LEN) begin : g_key
        assign seq_bytes[gi] = SEQ[gi*8 +: 8];
      end else begin : g_pad
        assign seq_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  assign bus.expected_code = seq_bytes[bus.pos];

  logic             key_match;
  logic [7:0]       pos_inc;
  logic [7:0]       pos_key;
  logic [ERR_W-1:0] err_key;
  logic             err_fail;

  assign key_match = (bus.fsm_data == seq_bytes[bus.pos]);
  assign pos_inc   = bus.pos + 8'd1;
`ifdef RETRY_ON_ERROR_EN
  assign pos_key   = key_match ? pos_inc : bus.pos;
`else
  assign pos_key   = pos_inc;
`endif
  assign err_key   = (key_match || bus.err_cnt == ERR_SAT) ? bus.err_cnt : bus.err_cnt + 1'b1;
  assign err_fail  = (MAX_ERR != 0) && (32'(err_key) >= 32'(MAX_ERR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bus.pos     <= '0;
      bus.err_cnt <= '0;
      bus.key_ok  <= 1'b0;
      bus.key_err <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.fail    <= 1'b0;
    end else begin
      bus.key_ok  <= 1'b0;
      bus.key_err <= 1'b0;
      if (bus.reset_signal) begin
        state_reg   <= IDLE;
        timer_reg   <= '0;
        bus.pos     <= '0;
        bus.err_cnt <= '0;
        bus.busy    <= 1'b0;
        bus.done    <= 1'b0;
        bus.fail    <= 1'b0;
      end else if (bus.set_signal) begin
        state_reg   <= RUN;
        timer_reg   <= '0;
        bus.pos     <= '0;
        bus.err_cnt <= '0;
        bus.busy    <= 1'b1;
        bus.done    <= 1'b0;
        bus.fail    <= 1'b0;
      end else if (state_reg == RUN) begin
        if (bus.code_valid) begin
          timer_reg   <= '0;
          bus.pos     <= pos_key;
          bus.err_cnt <= err_key;
          bus.key_ok  <= key_match;
          bus.key_err <= !key_match;
          // Error-fail outranks completion on the same key.
          if (err_fail) begin
            state_reg <= FAIL;
            bus.busy  <= 1'b0;
            bus.fail  <= 1'b1;
          end else if (pos_key == LEN8) begin
            state_reg <= DONE;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
          end
        end else begin
          timer_reg <= timer_reg + 32'd1;
          if (TIMEOUT_CYC != 0 && timer_reg == TIMEOUT_LAST) begin
            state_reg <= FAIL;
            bus.busy  <= 1'b0;
            bus.fail  <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_typing_trainer_fsm.sv
// Scoreboard bench for typing_trainer_fsm: a reference model pushes expected status per cycle.
module tb_typing_trainer_fsm;
  localparam int          LEN = 4;
  localparam logic [31:0] SEQ_T = 32'h44332211;
  localparam int          MAXE = 3;
  localparam int          TO = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typing_trainer_fsm_if #(.ERR_W(8)) bus ();

  typing_trainer_fsm #(
    .SEQ_LEN(LEN), .SEQ(SEQ_T), .MAX_ERR(MAXE), .ERR_W(8), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  typedef struct packed {
    logic [7:0] pos;
    logic [7:0] exp_code;
    logic [7:0] err_cnt;
    logic       key_ok;
    logic       key_err;
    logic       busy;
    logic       done;
    logic       fail;
  } obs_t;

  obs_t exp_q [$];
  int checks = 0;
  int errors = 0;

  // Reference model state: 0 IDLE, 1 RUN, 2 DONE, 3 FAIL
  int m_st, m_pos, m_err, m_timer;
  logic [31:0] seq_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic obs_t model_obs(input logic ok, input logic er);
    obs_t o;
    o.pos      = 8'(m_pos);
    o.exp_code = (m_pos < LEN) ? 8'((seq_v >> (m_pos * 8)) & 32'hff) : 8'h00;
    o.err_cnt  = 8'(m_err);
    o.key_ok   = ok;
    o.key_err  = er;
    o.busy     = (m_st == 1);
    o.done     = (m_st == 2);
    o.fail     = (m_st == 3);
    return o;
  endfunction

  task automatic compare_now(input string tag, input obs_t e);
    check({tag, ".pos"},      32'(bus.pos),           32'(e.pos));
    check({tag, ".exp_code"}, 32'(bus.expected_code), 32'(e.exp_code));
    check({tag, ".err_cnt"},  32'(bus.err_cnt),       32'(e.err_cnt));
    check({tag, ".key_ok"},   32'(bus.key_ok),        32'(e.key_ok));
    check({tag, ".key_err"},  32'(bus.key_err),       32'(e.key_err));
    check({tag, ".busy"},     32'(bus.busy),          32'(e.busy));
    check({tag, ".done"},     32'(bus.done),          32'(e.done));
    check({tag, ".fail"},     32'(bus.fail),          32'(e.fail));
  endtask

  task automatic model_reset();
    m_st = 0; m_pos = 0; m_err = 0; m_timer = 0;
  endtask

  // One clock: drive on negedge, predict, sample 1 ns after posedge.
  task automatic step(input string tag, input logic sv, input logic rv,
                      input logic cv, input logic [7:0] data);
    logic ok, er;
    obs_t e;
    @(negedge clk);
    bus.set_signal = sv; bus.reset_signal = rv; bus.code_valid = cv; bus.fsm_data = data;
    ok = 1'b0; er = 1'b0;
    if (rv) begin
      m_st = 0; m_pos = 0; m_err = 0; m_timer = 0;
    end else if (sv) begin
      m_st = 1; m_pos = 0; m_err = 0; m_timer = 0;
    end else if (m_st == 1) begin
      if (cv) begin
        m_timer = 0;
        if (data == 8'((seq_v >> (m_pos * 8)) & 32'hff)) begin
          ok = 1'b1; m_pos++;
        end else begin
          er = 1'b1;
          if (m_err < 255) m_err++;
`ifndef RETRY_ON_ERROR_EN
          m_pos++;
`endif
        end
        if (MAXE != 0 && m_err >= MAXE) m_st = 3;
        else if (m_pos == LEN) m_st = 2;
      end else begin
        if (m_timer == TO - 1) m_st = 3;
        m_timer++;
      end
    end
    exp_q.push_back(model_obs(ok, er));
    @(posedge clk);
    #1;
    bus.set_signal = 1'b0; bus.reset_signal = 1'b0; bus.code_valid = 1'b0;
    e = exp_q.pop_front();
    compare_now(tag, e);
    if (sv || rv || cv)
      $display("%0t %s: set=%0b rst=%0b key=%0b data=%02h -> pos=%0d err=%0d ok=%0b kerr=%0b done=%0b fail=%0b",
               $time, tag, sv, rv, cv, data, bus.pos, bus.err_cnt, bus.key_ok, bus.key_err,
               bus.done, bus.fail);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic key(input string tag, input logic [7:0] d, input int gap);
    step(tag, 1'b0, 1'b0, 1'b1, d);
    idle(gap);
  endtask

  initial begin
    seq_v = SEQ_T;
    bus.fsm_data = 8'h00; bus.code_valid = 1'b0;
    bus.set_signal = 1'b0; bus.reset_signal = 1'b0;
    model_reset();
    #12;
    compare_now("reset", model_obs(1'b0, 1'b0));
    check("reset.exp_lit", 32'(bus.expected_code), 32'h11);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle state ignores keys
    key("idle_key", 8'h11, 1);

    // Perfect run
    step("set", 1'b1, 1'b0, 1'b0, 8'h00);
    key("k11", 8'h11, 3); key("k22", 8'h22, 3); key("k33", 8'h33, 3); key("k44", 8'h44, 2);
    check("perfect.done", 32'(bus.done), 32'h1);
    key("done_key", 8'h55, 1);

    // One wrong key
    step("set", 1'b1, 1'b0, 1'b0, 8'h00);
    key("k11", 8'h11, 1); key("k99", 8'h99, 1);
`ifdef RETRY_ON_ERROR_EN
    check("retry.pos", 32'(bus.pos), 32'd1);
    key("k22", 8'h22, 1);
`endif
    key("k33", 8'h33, 1); key("k44", 8'h44, 1);
    check("onebad.done", 32'(bus.done), 32'h1);
    check("onebad.err", 32'(bus.err_cnt), 32'd1);

    // Error fail, then further keys ignored
    step("set", 1'b1, 1'b0, 1'b0, 8'h00);
    key("bad1", 8'h55, 0); key("bad2", 8'h66, 0); key("bad3", 8'h77, 0);
    check("errfail.fail", 32'(bus.fail), 32'h1);
    key("post1", 8'h11, 0); key("post2", 8'h55, 1);

    // Inactivity timeout: fail exactly TO cycles after the key strobe
    step("set", 1'b1, 1'b0, 1'b0, 8'h00);
    key("k11", 8'h11, TO - 1);
    check("to.not_yet", 32'(bus.fail), 32'h0);
    idle(1);
    check("to.fail", 32'(bus.fail), 32'h1);
    check("to.pos", 32'(bus.pos), 32'd1);
    idle(3);

    // reset_signal mid-run, then set with a simultaneous key
    step("set", 1'b1, 1'b0, 1'b0, 8'h00);
    key("k11", 8'h11, 0); key("k99", 8'h99, 0);
`ifdef RETRY_ON_ERROR_EN
    key("k22", 8'h22, 0);
`endif
    check("mid.pos", 32'(bus.pos), 32'd2);
    step("rsig", 1'b0, 1'b1, 1'b0, 8'h00);
    step("set_key", 1'b1, 1'b0, 1'b1, 8'h11);
    check("setkey.pos", 32'(bus.pos), 32'd0);

    // Asynchronous rst_n mid-run
    key("k11", 8'h11, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_now("async_rst", model_obs(1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    key("after1", 8'h11, 0); key("after2", 8'h22, 1);
    check("after.busy", 32'(bus.busy), 32'h0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
